// File: rtl/jump_branch_ctrl.sv
// jump_branch_ctrl: hard-wired miniSRC control for fetch, jr, jal, br, nop, halt.
// Optional macro JBC_JAL_EN enables the jal sequence.
module jump_branch_ctrl #(
   parameter int         MEM_WAIT = 2,
   parameter logic [4:0] ALU_ADD  = 5'b00011,
   parameter logic [4:0] ALU_NOP  = 5'b11010
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       run,
   input  logic [4:0] ir_op,
   input  logic       CONFF_out,
   output logic       PCout_en,
   output logic       IncPC,
   output logic       PC_en,
   output logic       IRin,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       memRead,
   output logic       Gra,
   output logic       Rin,
   output logic       Rout,
   output logic       Yin,
   output logic       Zin,
   output logic       Zlowout,
   output logic       Cout,
   output logic       CONin,
   output logic       jal_R15,
   output logic [4:0] opcode,
   output logic       halted,
   output logic       busy
);

   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_HALT = 5'b11010;
   localparam logic [1:0] W_LAST  = 2'(MEM_WAIT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_WAIT, S_T2, S_DEC,
      S_E1, S_E2, S_E3, S_E4, S_HALT
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_wcnt;
   logic [4:0] r_op;

   // State register, memory-wait counter and opcode latched at decode
   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_wcnt  <= 2'd0;
         r_op    <= 5'd0;
      end else begin
         r_state <= w_next;
         r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + 2'd1 : 2'd0;
         if (r_state == S_DEC)
            r_op <= ir_op;
      end
   end

   // Next-state sequencing
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: w_next = run ? S_T0 : S_IDLE;
         S_T0:   w_next = S_T1;
         S_T1:   w_next = S_WAIT;
         S_WAIT: w_next = (r_wcnt == W_LAST) ? S_T2 : S_WAIT;
         S_T2:   w_next = S_DEC;
         S_DEC: begin
            case (ir_op)
               OP_JR:   w_next = S_E1;
`ifdef JBC_JAL_EN
               OP_JAL:  w_next = S_E1;
`endif
               OP_BR:   w_next = S_E1;
               OP_HALT: w_next = S_HALT;
               default: w_next = S_T0;
            endcase
         end
         S_E1: begin
            case (r_op)
`ifdef JBC_JAL_EN
               OP_JAL:  w_next = S_E2;
`endif
               OP_BR:   w_next = S_E2;
               default: w_next = S_T0;
            endcase
         end
         S_E2:   w_next = (r_op == OP_BR) ? S_E3 : S_T0;
         S_E3:   w_next = S_E4;
         S_E4:   w_next = S_T0;
         S_HALT: w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

   // Moore output decode of the registered state
   always_comb begin
      PCout_en = 1'b0;
      IncPC    = 1'b0;
      PC_en    = 1'b0;
      IRin     = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      memRead  = 1'b0;
      Gra      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Cout     = 1'b0;
      CONin    = 1'b0;
      jal_R15  = 1'b0;
      opcode   = ALU_NOP;
      halted   = (r_state == S_HALT);
      busy     = (r_state != S_IDLE) && (r_state != S_HALT);
      case (r_state)
         S_T0: begin
            PCout_en = 1'b1;
            MARin    = 1'b1;
            IncPC    = 1'b1;
            Zin      = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PC_en   = 1'b1;
            memRead = 1'b1;
            MDRin   = 1'b1;
         end
         S_WAIT: begin
            memRead = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_E1: begin
            case (r_op)
               OP_JR: begin
                  Gra   = 1'b1;
                  Rout  = 1'b1;
                  PC_en = 1'b1;
               end
`ifdef JBC_JAL_EN
               OP_JAL: begin
                  PCout_en = 1'b1;
                  Rin      = 1'b1;
                  jal_R15  = 1'b1;
               end
`endif
               OP_BR: begin
                  Gra   = 1'b1;
                  Rout  = 1'b1;
                  CONin = 1'b1;
               end
               default: ;
            endcase
         end
         S_E2: begin
            if (r_op == OP_BR) begin
               PCout_en = 1'b1;
               Yin      = 1'b1;
            end else begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               PC_en = 1'b1;
            end
         end
         S_E3: begin
            Cout   = 1'b1;
            Zin    = 1'b1;
            opcode = ALU_ADD;
         end
         S_E4: begin
            Zlowout = 1'b1;
            PC_en   = CONFF_out;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_jump_branch_ctrl.sv
// tb_jump_branch_ctrl: directed checks plus randomized run against a
// schedule-queue model of the control sequence.
module tb_jump_branch_ctrl;

   localparam int         MW   = 2;
   localparam logic [4:0] AADD = 5'b00011;
   localparam logic [4:0] ANOP = 5'b11010;
   localparam logic [4:0] JR   = 5'b10011;
   localparam logic [4:0] JAL  = 5'b10100;
   localparam logic [4:0] BR   = 5'b10010;
   localparam logic [4:0] HLT  = 5'b11010;
   localparam logic [4:0] NOP  = 5'b11001;

   localparam logic [24:0] COND = 25'(1) << 24;
   localparam logic [24:0] PCO  = 25'(1) << 23;
   localparam logic [24:0] INC  = 25'(1) << 22;
   localparam logic [24:0] PCE  = 25'(1) << 21;
   localparam logic [24:0] IRI  = 25'(1) << 20;
   localparam logic [24:0] MAR  = 25'(1) << 19;
   localparam logic [24:0] MDI  = 25'(1) << 18;
   localparam logic [24:0] MDO  = 25'(1) << 17;
   localparam logic [24:0] MRD  = 25'(1) << 16;
   localparam logic [24:0] GRA  = 25'(1) << 15;
   localparam logic [24:0] RIN  = 25'(1) << 14;
   localparam logic [24:0] ROU  = 25'(1) << 13;
   localparam logic [24:0] YIN  = 25'(1) << 12;
   localparam logic [24:0] ZIN  = 25'(1) << 11;
   localparam logic [24:0] ZLO  = 25'(1) << 10;
   localparam logic [24:0] COU  = 25'(1) << 9;
   localparam logic [24:0] CON  = 25'(1) << 8;
   localparam logic [24:0] J15  = 25'(1) << 7;
   localparam logic [24:0] HLB  = 25'(2);
   localparam logic [24:0] BSY  = 25'(1);

   function automatic logic [24:0] ov(logic [24:0] s, logic [4:0] op);
      return s | {18'b0, op, 2'b0};
   endfunction

   localparam logic [24:0] IDLE_V = {18'b0, ANOP, 2'b0};
   localparam logic [24:0] HALT_V = {18'b0, ANOP, 2'b10};

   logic       clock = 1'b0;
   logic       clear, run, CONFF_out;
   logic [4:0] ir_op;
   logic PCout_en, IncPC, PC_en, IRin, MARin, MDRin, MDRout, memRead;
   logic Gra, Rin, Rout, Yin, Zin, Zlowout, Cout, CONin, jal_R15;
   logic [4:0] opcode;
   logic halted, busy;

   always #5 clock = ~clock;

   jump_branch_ctrl #(.MEM_WAIT(MW), .ALU_ADD(AADD), .ALU_NOP(ANOP)) dut (
      .clock(clock), .clear(clear), .run(run), .ir_op(ir_op),
      .CONFF_out(CONFF_out),
      .PCout_en(PCout_en), .IncPC(IncPC), .PC_en(PC_en), .IRin(IRin),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .memRead(memRead),
      .Gra(Gra), .Rin(Rin), .Rout(Rout), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .jal_R15(jal_R15),
      .opcode(opcode), .halted(halted), .busy(busy)
   );

   logic [24:0] dv;
   assign dv = {1'b0, PCout_en, IncPC, PC_en, IRin, MARin, MDRin, MDRout,
                memRead, Gra, Rin, Rout, Yin, Zin, Zlowout, Cout, CONin,
                jal_R15, opcode, halted, busy};

   // Model: mode 0 idle, 1 running, 2 halted; q holds scheduled cycles
   int          mode = 0;
   logic [24:0] q[$];
   logic [24:0] cur = IDLE_V;

   task automatic push_fetch();
      q.push_back(ov(PCO | MAR | INC | ZIN | BSY, ANOP));
      q.push_back(ov(ZLO | PCE | MRD | MDI | BSY, ANOP));
      for (int i = 0; i < MW; i++)
         q.push_back(ov(MRD | MDI | BSY, ANOP));
      q.push_back(ov(MDO | IRI | BSY, ANOP));
      q.push_back(ov(BSY, ANOP));
   endtask

   task automatic push_exec(logic [4:0] op);
      if (op == JR)
         q.push_back(ov(GRA | ROU | PCE | BSY, ANOP));
`ifdef JBC_JAL_EN
      if (op == JAL) begin
         q.push_back(ov(PCO | RIN | J15 | BSY, ANOP));
         q.push_back(ov(GRA | ROU | PCE | BSY, ANOP));
      end
`endif
      if (op == BR) begin
         q.push_back(ov(GRA | ROU | CON | BSY, ANOP));
         q.push_back(ov(PCO | YIN | BSY, ANOP));
         q.push_back(ov(COU | ZIN | BSY, AADD));
         q.push_back(ov(ZLO | COND | BSY, ANOP));
      end
   endtask

   always @(posedge clock) begin
      if (clear) begin
         mode = 0;
         q.delete();
         cur = IDLE_V;
      end else if (mode == 0) begin
         if (run) begin
            mode = 1;
            push_fetch();
            cur = q.pop_front();
         end else begin
            cur = IDLE_V;
         end
      end else if (mode == 2) begin
         cur = HALT_V;
      end else if (q.size() == 0) begin
         if (ir_op == HLT) begin
            mode = 2;
            cur = HALT_V;
         end else begin
            push_exec(ir_op);
            push_fetch();
            cur = q.pop_front();
         end
      end else begin
         cur = q.pop_front();
      end
   end

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      logic [24:0] e;
      @(negedge clock);
      if (chk_en) begin
         e = cur;
         if (e[24]) e[21] = CONFF_out;
         e[24] = 1'b0;
         chk("model_cmp", 32'(dv), 32'(e));
      end
      @(posedge clock);
      #1;
   endtask

   int n;

   initial begin
      clear = 1'b1; run = 1'b0; ir_op = NOP; CONFF_out = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("reset_out", 32'(dv), 32'(IDLE_V));
      clear = 1'b0;
      tick();
      chk("idle_hold", 32'(busy), 32'd0);

      // jr: E1 is the 7th cycle out of IDLE, then T0 immediately
      run = 1'b1; ir_op = JR;
      tick();
      n = 1;
      while (!(PC_en && Gra && Rout) && n < 20) begin tick(); n++; end
      chk("jr_latency", n, 7);
      chk("jr_model_e1", 32'(cur), 32'(ov(GRA | ROU | PCE | BSY, ANOP)));
      run = 1'b0; ir_op = BR; CONFF_out = 1'b1;
      tick();
      chk("jr_next_t0", 32'(MARin && PCout_en), 32'd1);

      // br taken: E3 at cycle 9 with ALU_ADD, PC_en in E4
      n = 1;
      while (opcode != AADD && n < 20) begin tick(); n++; end
      chk("br_e3_cycle", n, 9);
      chk("br_model_op", 32'(cur[6:2]), 32'(5'b00011));
      tick();
      chk("br_taken_pce", 32'({PC_en, Zlowout}), 32'b11);

      // br not taken
      CONFF_out = 1'b0;
      tick();
      n = 1;
      while (opcode != AADD && n < 20) begin tick(); n++; end
      chk("br_nt_e3", n, 9);
      tick();
      chk("br_nt_pce", 32'({PC_en, Zlowout}), 32'b01);

      // clear at E3 of a taken br: no PC commit
      CONFF_out = 1'b1;
      tick();
      n = 1;
      while (opcode != AADD && n < 20) begin tick(); n++; end
      chk("rst_e3_reach", n, 9);
      clear = 1'b1; run = 1'b0;
      tick();
      clear = 1'b0;
      chk("rst_idle", 32'(dv), 32'(IDLE_V));
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rst_no_pce", 32'({PC_en, busy}), 32'd0);
      end

      // jal
      run = 1'b1; ir_op = JAL;
      tick();
      run = 1'b0;
      n = 1;
`ifdef JBC_JAL_EN
      while (!jal_R15 && n < 20) begin tick(); n++; end
      chk("jal_r15_cycle", n, 7);
      tick();
      chk("jal_pce", 32'({PC_en, Gra, Rout}), 32'b111);
      tick();
`else
      tick(); n++;
      while (!MARin && n < 20) begin tick(); n++; end
      chk("jal_as_nop", n, 7);
`endif
      chk("jal_then_t0", 32'(MARin), 32'd1);

      // halt is sticky until clear
      ir_op = HLT;
      n = 1;
      while (!halted && n < 20) begin tick(); n++; end
      chk("halt_cycle", n, 7);
      run = 1'b1; ir_op = NOP;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("halt_sticky", 32'({halted, busy}), 32'b10);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0; run = 1'b0;
      chk("halt_clear", 32'(dv), 32'(IDLE_V));

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         clear = ($urandom_range(59) == 0) ||
                 (halted && $urandom_range(7) == 0);
         run = 1'($urandom_range(1));
         CONFF_out = 1'($urandom_range(1));
         r = $urandom_range(8);
         case (r)
            0: ir_op = JR;
            1: ir_op = JAL;
            2, 3: ir_op = BR;
            4: ir_op = NOP;
            5: ir_op = HLT;
            default: ir_op = 5'($urandom);
         endcase
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/jump_branch_ctrl.md
# jump_branch_ctrl

Hard-wired control unit that sequences the miniSRC datapath through instruction fetch and the control-transfer instructions: `jr`, `jal`, conditional branch, `nop` and `halt`. It drives the same one-hot control strobes that the datapath testbenches currently drive by hand, including the two memory-wait cycles on every fetch. It sits beside the `miniSRC` datapath and reads back the IR opcode field and the CON FF output.

## Interface
- `MEM_WAIT`, default 2: number of idle cycles between the fetch read and IR load (1..3).
- `ALU_ADD`, default 5'b00011: ALU opcode driven during branch-target add.
- `ALU_NOP`, default 5'b11010: ALU opcode driven whenever no ALU operation is required.
- `clock`  in  1  system clock, rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `run`  in  1  level enable, sampled only in `IDLE`.
- `ir_op`  in  5  IR[31:27], valid from the cycle after `T2`.
- `CONFF_out`  in  1  branch condition from the CON FF.
- `PCout_en`, `IncPC`, `PC_en`, `IRin`, `MARin`, `MDRin`, `MDRout`, `memRead`  out  1 each  PC, IR and memory strobes.
- `Gra`, `Rin`, `Rout`, `Yin`, `Zin`, `Zlowout`, `Cout`, `CONin`, `jal_R15`  out  1 each  register-file and ALU strobes.
- `opcode`  out  5  ALU opcode.
- `halted`  out  1  high while in `HALT`.
- `busy`  out  1  high in every state except `IDLE` and `HALT`.

## Operation
- Moore FSM. All outputs are a pure decode of the registered state. Any strobe not listed for a state is 0, and `opcode` = `ALU_NOP` unless listed otherwise.
- States: `IDLE`, `T0`, `T1`, `WAITn` (`MEM_WAIT` states), `T2`, `DEC`, `E1`..`E4`, `HALT`.
- `IDLE`: all strobes low. Go to `T0` when `run`=1, else stay.
- `T0`: `PCout_en`, `MARin`, `IncPC`, `Zin`.
- `T1`: `Zlowout`, `PC_en`, `memRead`, `MDRin`.
- `WAITn`: `memRead`, `MDRin` stay high. All other strobes are low.
- `T2`: `MDRout`, `IRin`.
- `DEC`: no strobes. The next state is chosen from `ir_op`:
  - 10011 (`jr`) → `E1`
  - 10100 (`jal`) → `E1`
  - 10010 (`br`) → `E1`
  - 11010 (`halt`) → `HALT`
  - anything else → `T0`. This covers `nop` (11001) and unsupported ops.
- `jr`: `E1` = `Gra`, `Rout`, `PC_en`, then → `T0`.
- `jal`:
  - `E1` = `PCout_en`, `Rin`, `jal_R15` (R15 ← PC).
  - `E2` = `Gra`, `Rout`, `PC_en`, then → `T0`.
- `br`:
  - `E1` = `Gra`, `Rout`, `CONin`.
  - `E2` = `PCout_en`, `Yin`.
  - `E3` = `Cout`, `Zin`, `opcode`=`ALU_ADD`.
  - `E4` = `Zlowout`, plus `PC_en` only if `CONFF_out`=1. Then → `T0`.
- `HALT`: sticky. All strobes are low and `halted`=1. Only `clear` leaves it.
- The opcode is latched internally at `DEC`. Changes on `ir_op` during `E*` are ignored.

## Timing
- Reset: when `clear`=1 at a rising edge, state goes to `IDLE`. This overrides any in-flight instruction with no partial commit. During and after reset, every output is 0 and `opcode`=`ALU_NOP`.
- Fetch takes 4 + `MEM_WAIT` cycles, from `T0` through `DEC`.
- Instruction totals with the default `MEM_WAIT`=2:
  - `nop`: 6 cycles
  - `jr`: 7 cycles
  - `jal`: 8 cycles
  - `br`: 10 cycles
- Back-to-back operation: after an instruction's last state, the next state is `T0` without passing through `IDLE`. `run` is not re-sampled.
- `CONFF_out` is sampled combinationally in `E4`. It must be stable from the end of `E1`.
- `PC_en` and `IRin` are never high in the same cycle.
- `memRead` is high for exactly 1 + `MEM_WAIT` consecutive cycles per fetch.

## Configuration
- `JBC_JAL_EN`
  - Defined: `jal` is decoded as above.
  - Undefined: 10100 falls into the "anything else" path (treated as `nop`), `jal_R15` is tied to 0, and state `E2` is reachable only through `br`.

## Test plan
- Reset: pulse `clear` mid-`br` at `E3`. Next cycle: state is `IDLE`, all strobes are 0, `PC_en` never fires.
- `jr`: R5=0x0000_0040, IR=`jr R5`. `PC_en`+`Gra`+`Rout` fire exactly 7 cycles after leaving `IDLE`, and PC reads 0x40. The next `T0` follows immediately.
- `jal`: PC=0x10, R3=0x80. R15 = 0x11 (the incremented PC) and PC = 0x80 after 8 cycles. Repeat with `JBC_JAL_EN` undefined: PC = 0x11 after 6 cycles and R15 is unchanged.
- `br`, taken and not taken: `brzr R2,+5` at PC=0x20.
  - With R2=0: PC = 0x26.
  - With R2=1: PC = 0x21, and `PC_en` is low in `E4`.
  - `opcode`=`ALU_ADD` only in `E3` in both cases.
- `halt`, then `nop`: `halted`=1 and `busy`=0 from the cycle after `DEC`. It stays that way for 20 cycles even with `run`=1, and `clear` returns the block to `IDLE`.
